// File: rtl/gray_code_pkg.sv
// Shared constants for the Gray-code conversion pipeline: per-beat mode
// encodings and legal parameter ranges.
package gray_code_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  localparam int WIDTH_MIN  = 2;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/gray_code_pipe_stage.sv
// One register slice of the pipeline: holds a word plus valid and loads when
// empty or when its current contents move on in the same cycle.
module gray_code_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         prev_valid,
  output logic         prev_ready,
  input  logic [W-1:0] prev_data,
  output logic         next_valid,
  input  logic         next_ready,
  output logic [W-1:0] next_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign prev_ready = !valid_q || next_ready;
  assign next_valid = valid_q;
  assign next_data  = data_q;

  // Data only changes on a real load, so a stalled or drained slice keeps its word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (prev_ready) begin
      valid_q <= prev_valid;
      if (prev_valid) data_q <= prev_data;
    end
  end

endmodule

// File: rtl/gray_code_pipe.sv
// Per-beat Gray<->binary converter followed by a STAGES-deep elastic pipeline.
// Optional out_parity port is enabled by defining GRAY_CODE_PIPE_PARITY_EN.
module gray_code_pipe
  import gray_code_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef GRAY_CODE_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_mode
);

`ifdef GRAY_CODE_PIPE_PARITY_EN
  localparam int SW = WIDTH + 2;
`else
  localparam int SW = WIDTH + 1;
`endif

  logic [WIDTH-1:0] bin_word;
  logic [WIDTH-1:0] gray_word;
  logic [WIDTH-1:0] conv_word;

  always_comb begin
    bin_word = '0;
    bin_word[WIDTH-1] = in_data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_word[i] = bin_word[i+1] ^ in_data[i];
    end
  end

  assign gray_word = in_data ^ (in_data >> 1);
  assign conv_word = (in_mode == MODE_B2G) ? gray_word : bin_word;

  logic          v_chain [0:STAGES];
  logic          r_chain [0:STAGES];
  logic [SW-1:0] d_chain [0:STAGES];

  // Gating with rst keeps the upstream handshake closed while reset is held.
  assign v_chain[0] = in_valid & ~rst;
  assign in_ready   = r_chain[0] & ~rst;
  assign r_chain[STAGES] = out_ready;

`ifdef GRAY_CODE_PIPE_PARITY_EN
  assign d_chain[0] = {^conv_word, in_mode, conv_word};
`else
  assign d_chain[0] = {in_mode, conv_word};
`endif

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    gray_code_pipe_stage #(.W(SW)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .prev_valid (v_chain[g]),
      .prev_ready (r_chain[g]),
      .prev_data  (d_chain[g]),
      .next_valid (v_chain[g+1]),
      .next_ready (r_chain[g+1]),
      .next_data  (d_chain[g+1])
    );
  end

  assign out_valid = v_chain[STAGES];
  assign out_data  = d_chain[STAGES][WIDTH-1:0];
  assign out_mode  = d_chain[STAGES][WIDTH];
`ifdef GRAY_CODE_PIPE_PARITY_EN
  assign out_parity = d_chain[STAGES][WIDTH+1];
`endif

endmodule

// File: tb/tb_gray_code_pipe.sv
// Directed bench: a WIDTH=4/STAGES=1 instance and a WIDTH=8/STAGES=3 instance
// checked against hand-computed conversions and handshake timing.
module tb_gray_code_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [3:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
  logic [7:0] b_in_data, b_out_data;
`ifdef GRAY_CODE_PIPE_PARITY_EN
  logic       a_out_parity, b_out_parity;
`endif

  gray_code_pipe #(.WIDTH(4), .STAGES(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef GRAY_CODE_PIPE_PARITY_EN
    .out_parity(a_out_parity),
`endif
    .out_mode(a_out_mode)
  );

  gray_code_pipe #(.WIDTH(8), .STAGES(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef GRAY_CODE_PIPE_PARITY_EN
    .out_parity(b_out_parity),
`endif
    .out_mode(b_out_mode)
  );

  task automatic cyc_b(input logic iv, input logic [7:0] id, input logic im, input logic ordy,
                       output logic acc, output logic emit);
    @(negedge clk);
    b_in_valid  = iv;
    b_in_data   = id;
    b_in_mode   = im;
    b_out_ready = ordy;
    #1;
    acc  = iv && b_in_ready;
    emit = b_out_valid && ordy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_mode = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_mode = 0; b_out_ready = 1;
    #1;
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL rst_b_out_valid got=%b want=0", b_out_valid); end
    total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL rst_b_in_ready got=%b want=0", b_in_ready); end
    total++; if (b_out_data !== 8'h00) begin bad++; $display("FAIL rst_b_out_data got=%h want=00", b_out_data); end
    total++; if (b_out_mode !== 1'b0) begin bad++; $display("FAIL rst_b_out_mode got=%b want=0", b_out_mode); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_a_out_valid got=%b want=0", a_out_valid); end
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_a_in_ready got=%b want=0", a_in_ready); end
    total++; if (a_out_data !== 4'h0) begin bad++; $display("FAIL rst_a_out_data got=%h want=0", a_out_data); end
`ifdef GRAY_CODE_PIPE_PARITY_EN
    total++; if (b_out_parity !== 1'b0) begin bad++; $display("FAIL rst_b_out_parity got=%b want=0", b_out_parity); end
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rel_b_in_ready got=%b want=1", b_in_ready); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rel_a_in_ready got=%b want=1", a_in_ready); end
  endtask

  task automatic test_g2b_w4;
    @(negedge clk);
    a_in_valid = 1; a_in_data = 4'b1111; a_in_mode = 0; a_out_ready = 1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL w4_in_ready got=%b want=1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL w4_early_valid got=%b want=0", a_out_valid); end
    @(negedge clk);
    a_in_data = 4'b0100;
    #1;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 4'b1010 || a_out_mode !== 1'b0) begin
      bad++; $display("FAIL w4_1111 got=%b/%b want=1/1010", a_out_valid, a_out_data); end
    @(negedge clk);
    a_in_valid = 0;
    #1;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 4'b0111) begin
      bad++; $display("FAIL w4_0100 got=%b/%b want=1/0111", a_out_valid, a_out_data); end
    @(negedge clk);
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL w4_drain got=%b want=0", a_out_valid); end
  endtask

  task automatic test_sweep;
    logic acc, emit;
    logic [7:0] prev, exp;
    int n, k, first, last;
    for (int pass = 0; pass < 2; pass++) begin
      n = 0; k = 0; first = -1; last = -1; prev = '0;
      for (int c = 0; c < 270; c++) begin
        if (pass == 0) cyc_b(n < 256, 8'(n), 1'b1, 1'b1, acc, emit);
        else           cyc_b(n < 256, 8'(n) ^ (8'(n) >> 1), 1'b0, 1'b1, acc, emit);
        if (emit) begin
          exp = (pass == 0) ? (8'(k) ^ (8'(k) >> 1)) : 8'(k);
          total++;
          if (b_out_data !== exp || b_out_mode !== (pass == 0)) begin
            bad++; $display("FAIL sweep%0d_k%0d got=%h/%b want=%h", pass, k, b_out_data, b_out_mode, exp); end
          if (pass == 0 && k > 0) begin
            total++;
            if ($countones(b_out_data ^ prev) != 1) begin
              bad++; $display("FAIL sweep_onebit_k%0d got=%h prev=%h want=1 bit diff", k, b_out_data, prev); end
          end
          prev = b_out_data;
          if (k == 0) first = c;
          last = c;
          k++;
        end
        if (acc) n++;
      end
      total++; if (k != 256) begin bad++; $display("FAIL sweep%0d_count got=%0d want=256", pass, k); end
      total++; if (first != 3) begin bad++; $display("FAIL sweep%0d_latency got=%0d want=3", pass, first); end
      total++; if (last != 258) begin bad++; $display("FAIL sweep%0d_throughput got=%0d want=258", pass, last); end
    end
  endtask

  task automatic test_stall;
    logic acc, emit;
    logic [7:0] din [4];
    logic [7:0] dexp [4];
    logic [7:0] held;
    int n, k;
    din  = '{8'h10, 8'h23, 8'h3C, 8'hFF};
    dexp = '{8'h18, 8'h32, 8'h22, 8'h80};
    n = 0; k = 0; held = '0;
    for (int c = 0; c < 20; c++) begin
      cyc_b(n < 4, din[(n < 4) ? n : 0], 1'b1, c >= 5, acc, emit);
      if (c == 3) begin
        held = b_out_data;
        total++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h18) begin
          bad++; $display("FAIL stall_first got=%b/%h want=1/18", b_out_valid, b_out_data); end
      end
      if (c == 4) begin
        total++; if (n != 3) begin bad++; $display("FAIL stall_accepted got=%0d want=3", n); end
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", b_in_ready); end
        total++; if (b_out_valid !== 1'b1 || b_out_data !== held) begin
          bad++; $display("FAIL stall_hold got=%b/%h want=1/%h", b_out_valid, b_out_data, held); end
      end
      if (emit) begin
        total++;
        if (k >= 4 || b_out_data !== dexp[k] || c != 5 + k) begin
          bad++; $display("FAIL stall_emit%0d got=%h at cycle %0d want=%h at %0d", k, b_out_data, c, dexp[k % 4], 5 + k); end
        k++;
      end
      if (acc) n++;
    end
    total++; if (k != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", k); end
  endtask

  task automatic test_mixed_modes;
    logic acc, emit;
    logic [7:0] din [6];
    logic [7:0] dexp [6];
    logic       mode [6];
    int n, k, extra;
    din  = '{8'hFF, 8'hFF, 8'h80, 8'h55, 8'h01, 8'hA5};
    mode = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dexp = '{8'hAA, 8'h80, 8'hFF, 8'h7F, 8'h01, 8'hF7};
    n = 0; k = 0; extra = 0;
    for (int c = 0; c < 200 && k < 6; c++) begin
      cyc_b(n < 6, din[(n < 6) ? n : 0], mode[(n < 6) ? n : 0], 1'($urandom_range(0, 1)), acc, emit);
      if (emit) begin
        total++;
        if (b_out_data !== dexp[k] || b_out_mode !== mode[k]) begin
          bad++; $display("FAIL mixed_%0d got=%h/%b want=%h/%b", k, b_out_data, b_out_mode, dexp[k], mode[k]); end
        k++;
      end
      if (acc) n++;
    end
    total++; if (k != 6) begin bad++; $display("FAIL mixed_timeout got=%0d beats want=6", k); end
    for (int c = 0; c < 6; c++) begin
      cyc_b(1'b0, 8'h00, 1'b0, 1'b1, acc, emit);
      if (emit) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL mixed_dup got=%0d extra want=0", extra); end
  endtask

  task automatic test_reset_midstream;
    logic acc, emit;
    int n, extra;
    n = 0; extra = 0;
    cyc_b(1'b1, 8'h11, 1'b1, 1'b0, acc, emit); if (acc) n++;
    cyc_b(1'b1, 8'h22, 1'b1, 1'b0, acc, emit); if (acc) n++;
    cyc_b(1'b0, 8'h00, 1'b0, 1'b0, acc, emit);
    cyc_b(1'b0, 8'h00, 1'b0, 1'b0, acc, emit);
    total++; if (n != 2 || b_out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre got=%0d/%b want=2/1", n, b_out_valid); end
    rst = 1'b1;
    #1;
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", b_out_valid); end
    total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b want=0", b_in_ready); end
    total++; if (b_out_data !== 8'h00) begin bad++; $display("FAIL mid_out_data got=%h want=00", b_out_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%b want=1", b_in_ready); end
    for (int c = 0; c < 8; c++) begin
      cyc_b(1'b0, 8'h00, 1'b0, 1'b1, acc, emit);
      if (emit) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL mid_leak got=%0d beats want=0", extra); end
  endtask

`ifdef GRAY_CODE_PIPE_PARITY_EN
  task automatic test_parity;
    logic acc, emit;
    logic [7:0] din [2];
    logic       mode [2];
    logic [7:0] dexp [2];
    logic       pexp [2];
    int n, k;
    din  = '{8'hF7, 8'h01};
    mode = '{1'b0, 1'b1};
    dexp = '{8'hA5, 8'h01};
    pexp = '{1'b0, 1'b1};
    n = 0; k = 0;
    for (int c = 0; c < 12 && k < 2; c++) begin
      cyc_b(n < 2, din[(n < 2) ? n : 0], mode[(n < 2) ? n : 0], 1'b1, acc, emit);
      if (emit) begin
        total++;
        if (b_out_data !== dexp[k] || b_out_parity !== pexp[k]) begin
          bad++; $display("FAIL parity_%0d got=%h/%b want=%h/%b", k, b_out_data, b_out_parity, dexp[k], pexp[k]); end
        k++;
      end
      if (acc) n++;
    end
    total++; if (k != 2) begin bad++; $display("FAIL parity_timeout got=%0d want=2", k); end
  endtask
`endif

  initial begin
    test_reset();
    test_g2b_w4();
    test_sweep();
    test_stall();
    test_mixed_modes();
    test_reset_midstream();
`ifdef GRAY_CODE_PIPE_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_code_pipe.md
GRAY_CODE_PIPE -- requirements
Module: gray_code_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: code word width; legal range 2..32.
REQ-002 SHALL provide parameter STAGES, default 2: pipeline depth in register stages; legal range 1..4.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have in_valid  input  1  upstream beat present.
REQ-006 SHALL have in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have in_data  input  WIDTH  code word to convert.
REQ-008 SHALL have in_mode  input  1  per-beat direction: 0 = Gray-to-binary, 1 = binary-to-Gray.
REQ-009 SHALL have out_valid  output  1  result beat present.
REQ-010 SHALL have out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have out_data  output  WIDTH  converted word.
REQ-012 SHALL have out_mode  output  1  in_mode of the beat carried alongside out_data.

Function
REQ-013 A beat SHALL transfer on input when in_valid and in_ready are both high at a clk edge; on output when out_valid and out_ready are both high.
REQ-014 Gray-to-binary SHALL compute b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-015 Binary-to-Gray SHALL compute g = b XOR (b >> 1), with the MSB passed through unchanged.
REQ-016 Conversion SHALL be combinational ahead of stage 0; stages 1..STAGES-1 SHALL be pure delay registers with per-stage valid.
REQ-017 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when no stall occurs.
REQ-018 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-019 A stage SHALL load when it is empty or its contents advance in the same cycle; bubbles SHALL collapse.
REQ-020 in_ready SHALL be high when stage 0 is empty or stage 0 advances in the same cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 While out_valid is high and out_ready is low, out_data, out_mode and out_valid SHALL hold stable.
REQ-022 Mode SHALL be per beat; mixed modes on back-to-back beats SHALL emerge in order, each converted per its own mode.
REQ-023 Beats SHALL never be dropped or duplicated; output order SHALL equal input order.
REQ-024 Simultaneous input and output transfer with the pipe full SHALL sustain full throughput with no lost beat.

Reset
REQ-025 rst high SHALL immediately clear all stage valids, so out_valid = 0 and in_ready = 0 while rst is high.
REQ-026 On reset, out_data SHALL be 0 and out_mode SHALL be 0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight beats; in_ready SHALL be 1 on the first clk edge after rst deasserts.

Configuration
REQ-028 With macro GRAY_CODE_PIPE_PARITY_EN defined, the block SHALL add output out_parity (1 bit) equal to the XOR of all out_data bits, registered alongside the data, 0 on reset, and held during stalls.
REQ-029 Without GRAY_CODE_PIPE_PARITY_EN, port out_parity and its logic SHALL be absent.

Structure
REQ-030 Package gray_code_pkg SHALL hold the mode constants MODE_G2B = 0 and MODE_B2G = 1, plus the WIDTH and STAGES legal-range constants.
REQ-031 The block SHALL instantiate sub-module gray_code_pipe_stage, one per stage: a single register slice with valid and the load/advance handshake.

Verification
REQ-032 WIDTH=4, STAGES=1, mode 0: in_data 4'b1111 -> out_data 4'b1010 one cycle after transfer; 4'b0100 -> 4'b0111.
REQ-033 WIDTH=8, mode 1: sweep 0..255 -> each output equals b^(b>>1), and successive outputs differ in exactly one bit; the Gray-to-binary round trip returns the original value.
REQ-034 STAGES=3, out_ready low for 5 cycles while 4 beats are offered -> 3 beats accepted, in_ready = 0, out_data held; on release all 4 emerge in order at 1 per cycle.
REQ-035 Alternating modes on 6 consecutive beats with random out_ready -> out_mode and out_data match a reference model in order, with no loss.
REQ-036 rst pulsed with 2 beats in flight -> out_valid = 0 asynchronously, neither beat emerges, and in_ready = 1 after release.
REQ-037 With GRAY_CODE_PIPE_PARITY_EN, WIDTH=8: out_data 8'hA5 -> out_parity = 0, 8'h01 -> out_parity = 1.
